// File: rtl/isp_raw_tpg.sv
// Raw Bayer test-pattern and video-timing generator for the ISP front end.
// Define ISP_TPG_DEFECT_INJ_EN to build hot-pixel injection (defect_en).
`timescale 1ns/1ps
module isp_raw_tpg #(
   parameter int BITS    = 8,
   parameter int WIDTH   = 1280,
   parameter int HEIGHT  = 960,
   parameter int H_BLANK = 160,
   parameter int V_SYNC  = 4,
   parameter int V_BP    = 16,
   parameter int V_FP    = 16,
   parameter int BAYER   = 0
) (
   input  logic            pclk,
   input  logic            rst_n,
   input  logic            enable,
   input  logic [1:0]      pattern,
   input  logic [BITS-1:0] flat_val,
   input  logic            defect_en,
   output logic            out_href,
   output logic            out_vsync,
   output logic [BITS-1:0] out_raw,
   output logic            frame_done
);
   localparam int L  = WIDTH + H_BLANK;
   localparam int NL = V_SYNC + V_BP + HEIGHT + V_FP;
   localparam int XW = ($clog2(L) > 5) ? $clog2(L) : 5;
   localparam int YW = ($clog2(NL) > 5) ? $clog2(NL) : 5;
   localparam logic [XW-1:0] X_LAST = XW'(L - 1);
   localparam logic [1:0]    BAY    = 2'(BAYER);

   typedef enum logic [2:0] {
      S_IDLE, S_VSYNC, S_VBP, S_ACT, S_VFP
   } state_t;

   state_t          state_q, state_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic [1:0]      pat_q, pat_d;
   logic [BITS-1:0] flat_q, flat_d;
   logic            href_q, href_d;
   logic            vsync_q, vsync_d;
   logic [BITS-1:0] raw_q, raw_d;
   logic            done_q, done_d;
   logic            line_end, last_line, enter;
   logic [1:0]      ch;
   logic [2:0]      bar;
   logic            bar_on;
   logic [BITS-1:0] pix;
`ifdef ISP_TPG_DEFECT_INJ_EN
   logic            dfe_q, dfe_d;
`else
   wire             unused_defect_en = defect_en;
`endif

   // Pattern for the pixel the FSM is on now; registered below.
   always_comb begin
      ch  = BAY ^ {y_q[0], x_q[0]};
      bar = '0;
      for (int k = 1; k < 8; k++) begin
         if (32'(x_q) * 32'd8 >= 32'(k * WIDTH)) bar = 3'(k);
      end
      unique case (ch)
         2'd0:    bar_on = bar[2];
         2'd3:    bar_on = bar[0];
         default: bar_on = bar[1];
      endcase
      unique case (pat_q)
         2'd0:    pix = flat_q;
         2'd1:    pix = BITS'(x_q);
         2'd2:    pix = {BITS{bar_on}};
         default: pix = {BITS{x_q[3] ^ y_q[3]}};
      endcase
`ifdef ISP_TPG_DEFECT_INJ_EN
      if (dfe_q && x_q[4:0] == 5'd16 && y_q[4:0] == 5'd16)
         pix = '1;
`endif
   end

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      pat_d     = pat_q;
      flat_d    = flat_q;
      enter     = 1'b0;
      last_line = 1'b0;
      line_end  = (x_q == X_LAST);
      unique case (state_q)
         S_VSYNC: last_line = (y_q == YW'(V_SYNC - 1));
         S_VBP:   last_line = (y_q == YW'(V_BP - 1));
         S_ACT:   last_line = (y_q == YW'(HEIGHT - 1));
         S_VFP:   last_line = (y_q == YW'(V_FP - 1));
         default: last_line = 1'b0;
      endcase
      if (state_q == S_IDLE) begin
         x_d = '0;
         y_d = '0;
         if (enable) begin
            state_d = S_VSYNC;
            enter   = 1'b1;
         end
      end else begin
         x_d = line_end ? '0 : x_q + 1'b1;
         if (line_end) begin
            y_d = last_line ? '0 : y_q + 1'b1;
            if (last_line) begin
               unique case (state_q)
                  S_VSYNC: state_d = S_VBP;
                  S_VBP:   state_d = S_ACT;
                  S_ACT:   state_d = S_VFP;
                  S_VFP: begin
                     state_d = enable ? S_VSYNC : S_IDLE;
                     enter   = enable;
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
      end
      if (enter) begin
         pat_d  = pattern;
         flat_d = flat_val;
      end
   end

`ifdef ISP_TPG_DEFECT_INJ_EN
   always_comb begin
      dfe_d = dfe_q;
      if (enter) dfe_d = defect_en;
   end
`endif

   always_comb begin
      vsync_d = (state_q == S_VSYNC);
      href_d  = (state_q == S_ACT) && (x_q < XW'(WIDTH));
      raw_d   = href_d ? pix : '0;
      done_d  = (state_q == S_VFP) && line_end && last_line;
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         pat_q   <= '0;
         flat_q  <= '0;
         href_q  <= 1'b0;
         vsync_q <= 1'b0;
         raw_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         pat_q   <= pat_d;
         flat_q  <= flat_d;
         href_q  <= href_d;
         vsync_q <= vsync_d;
         raw_q   <= raw_d;
         done_q  <= done_d;
      end
   end

`ifdef ISP_TPG_DEFECT_INJ_EN
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) dfe_q <= 1'b0;
      else        dfe_q <= dfe_d;
   end
`endif

   assign out_href   = href_q;
   assign out_vsync  = vsync_q;
   assign out_raw    = raw_q;
   assign frame_done = done_q;
endmodule

// File: tb/tb_isp_raw_tpg.sv
// Scoreboard bench for isp_raw_tpg: small 8x4 instance plus a 64x64
// instance for hot-pixel checks; both share all inputs.
`timescale 1ns/1ps
module tb_isp_raw_tpg;
   localparam int W  = 8;
   localparam int H  = 4;
   localparam int HB = 4;
   localparam int L  = W + HB;
   localparam int FR = (3 + H) * L;
   localparam int W6 = 64;
   localparam int H6 = 64;
`ifdef ISP_TPG_DEFECT_INJ_EN
   localparam bit DFX = 1'b1;
`else
   localparam bit DFX = 1'b0;
`endif

   typedef struct packed {
      logic       href;
      logic       vsync;
      logic [7:0] raw;
      logic       fd;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad = 0;

   logic       pclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       defect_en = 1'b0;
   logic       sel = 1'b0;
   logic [1:0] pattern = 2'd0;
   logic [7:0] flat_val = 8'h00;

   logic       href0, vsync0, fd0;
   logic [7:0] raw0;
   logic       href6, vsync6, fd6;
   logic [7:0] raw6;
   exp_t       obs;

   always #5 pclk = ~pclk;

   isp_raw_tpg #(
      .BITS(8), .WIDTH(W), .HEIGHT(H), .H_BLANK(HB),
      .V_SYNC(1), .V_BP(1), .V_FP(1), .BAYER(0)
   ) dut (
      .pclk(pclk), .rst_n(rst_n), .enable(enable),
      .pattern(pattern), .flat_val(flat_val),
      .defect_en(defect_en), .out_href(href0),
      .out_vsync(vsync0), .out_raw(raw0),
      .frame_done(fd0)
   );

   isp_raw_tpg #(
      .BITS(8), .WIDTH(W6), .HEIGHT(H6), .H_BLANK(HB),
      .V_SYNC(1), .V_BP(1), .V_FP(1), .BAYER(0)
   ) dut6 (
      .pclk(pclk), .rst_n(rst_n), .enable(enable),
      .pattern(pattern), .flat_val(flat_val),
      .defect_en(defect_en), .out_href(href6),
      .out_vsync(vsync6), .out_raw(raw6),
      .frame_done(fd6)
   );

   assign obs = sel ? {href6, vsync6, raw6, fd6}
                    : {href0, vsync0, raw0, fd0};

   function automatic logic [7:0] model_px(int pat, logic [7:0] flat,
                                           int x, int y, int w, bit dfx);
      int ch, b;
      bit on;
      logic [7:0] p;
      ch = ((y & 1) << 1) | (x & 1);
      b  = (x * 8) / w;
      if (ch == 0)      on = ((b >> 2) & 1) == 1;
      else if (ch == 3) on = (b & 1) == 1;
      else              on = ((b >> 1) & 1) == 1;
      case (pat)
         0:       p = flat;
         1:       p = 8'(x);
         2:       p = on ? 8'hFF : 8'h00;
         default: p = ((((x >> 3) ^ (y >> 3)) & 1) == 1) ? 8'hFF : 8'h00;
      endcase
      if (dfx && (x % 32) == 16 && (y % 32) == 16) p = 8'hFF;
      return p;
   endfunction

   task automatic push_frame(int pat, logic [7:0] flat, int w, int h, bit dfx);
      int l, n;
      exp_t e;
      l = w + HB;
      n = (3 + h) * l;
      for (int t = 0; t < n; t++) begin
         int ln, x;
         ln = t / l;
         x  = t % l;
         e  = '0;
         if (ln == 0) e.vsync = 1'b1;
         else if (ln >= 2 && ln < 2 + h && x < w) begin
            e.href = 1'b1;
            e.raw  = model_px(pat, flat, x, ln - 2, w, dfx);
         end
         e.fd = (t == n - 1);
         sb.push_back(e);
      end
   endtask

   task automatic push_idle(int n);
      for (int i = 0; i < n; i++) sb.push_back('0);
   endtask

   // Enable must have been raised at the current negedge with the DUT idle.
   task automatic play(int drop_t, int chg_t, logic [7:0] nf, string nm);
      exp_t e;
      int t;
      @(negedge pclk);
      total++;
      if (obs !== '0) begin
         bad++;
         $display("FAIL %s first_edge: got %h want 0", nm, obs);
      end
      t = 0;
      while (sb.size() > 0) begin
         @(negedge pclk);
         e = sb.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL %s t=%0d got href=%b vs=%b raw=%h fd=%b want href=%b vs=%b raw=%h fd=%b",
                     nm, t, obs.href, obs.vsync, obs.raw, obs.fd,
                     e.href, e.vsync, e.raw, e.fd);
         end
         if (t == drop_t) enable = 1'b0;
         if (t == chg_t) flat_val = nf;
         t++;
      end
   endtask

   task automatic do_reset();
      @(negedge pclk);
      rst_n = 1'b0;
      enable = 1'b0;
      defect_en = 1'b0;
      sel = 1'b0;
      @(negedge pclk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge pclk);
      rst_n = 1'b0;
      #2;
      total++;
      if ({href0, vsync0, raw0, fd0, href6, vsync6, raw6, fd6} !== '0) begin
         bad++;
         $display("FAIL reset_hold: got %b %b %h %b want 0 0 00 0",
                  href0, vsync0, raw0, fd0);
      end
      @(negedge pclk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge pclk);
         total++;
         if (obs !== '0) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d: got %h want 0", i, obs);
         end
      end
   endtask

   task automatic test_flat();
      do_reset();
      push_frame(0, 8'h5A, W, H, 1'b0);
      push_frame(0, 8'h33, W, H, 1'b0);
      push_idle(2 * L);
      @(negedge pclk);
      pattern = 2'd0;
      flat_val = 8'h5A;
      enable = 1'b1;
      play(FR + 10, 40, 8'h33, "flat");
   endtask

   task automatic test_pattern(int pat, string nm);
      do_reset();
      push_frame(pat, 8'h00, W, H, 1'b0);
      push_idle(L);
      @(negedge pclk);
      pattern = 2'(pat);
      flat_val = 8'h00;
      enable = 1'b1;
      play(30, -1, 8'h00, nm);
   endtask

   task automatic test_enable_drop();
      do_reset();
      push_frame(1, 8'h00, W, H, 1'b0);
      push_idle(2 * FR);
      @(negedge pclk);
      pattern = 2'd1;
      enable = 1'b1;
      play(4 * L + 3, -1, 8'h00, "en_drop");
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge pclk);
      pattern = 2'd1;
      enable = 1'b1;
      repeat (53) @(negedge pclk);
      total++;
      if (href0 !== 1'b1 || raw0 !== 8'h03) begin
         bad++;
         $display("FAIL pre_reset: got href=%b raw=%h want 1 03", href0, raw0);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({href0, vsync0, raw0, fd0} !== '0) begin
         bad++;
         $display("FAIL async_reset: got %b %b %h %b want 0 0 00 0",
                  href0, vsync0, raw0, fd0);
      end
      @(negedge pclk);
      rst_n = 1'b1;
      push_frame(1, 8'h00, W, H, 1'b0);
      push_idle(L);
      play(20, -1, 8'h00, "rst_restart");
   endtask

   task automatic test_defect();
      do_reset();
      sel = 1'b1;
      push_frame(0, 8'h20, W6, H6, DFX);
      push_idle(10);
      @(negedge pclk);
      pattern = 2'd0;
      flat_val = 8'h20;
      defect_en = 1'b1;
      enable = 1'b1;
      play(100, -1, 8'h00, "defect");
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_flat();
      test_pattern(1, "ramp");
      test_pattern(2, "bars");
      test_pattern(3, "checker");
      test_enable_drop();
      test_reset_mid();
      test_defect();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
